// File: rtl/motor_input_conditioner.sv
// Conditions the raw pushbutton and the two limit switches: 2-flop synchroniser,
// per-channel stability-count debounce, one-cycle press pulse and both-limits fault flag.
module motor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  input  logic up_limit_raw,
  input  logic dn_limit_raw,
  output logic activate,
  output logic up_limit,
  output logic dn_limit,
  output logic button_db,
  output logic limit_fault
);

  localparam int BTN = 0;
  localparam int UP  = 1;
  localparam int DN  = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]            raw;
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            db_q;
  logic [2:0]            db_next;
  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_next;
  logic                  fault_next;
  logic                  activate_q;
  logic                  fault_q;

  assign raw = {dn_limit_raw, up_limit_raw, button_raw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Any sample that agrees with the current level restarts that channel's count,
  // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips the level.
  always_comb begin
    db_next  = db_q;
    cnt_next = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fault_next = db_next[UP] & db_next[DN];

  // A press that debounces while a fault is present or being raised is dropped for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q       <= '0;
      cnt_q      <= '0;
      activate_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      db_q       <= db_next;
      cnt_q      <= cnt_next;
      activate_q <= db_next[BTN] & ~db_q[BTN] & ~fault_next;
      fault_q    <= fault_next;
    end
  end

  assign activate    = activate_q;
  assign button_db   = db_q[BTN];
  assign up_limit    = db_q[UP];
  assign dn_limit    = db_q[DN];
  assign limit_fault = fault_q;

endmodule
